// File: rtl/rgb_pwm_fader.sv
// N-channel PWM LED driver with linear fading and period-aligned duty updates.
// Build option: define RGB_PWM_FADER_GAMMA_EN to map each duty through an approximate gamma-2 curve.
module rgb_pwm_fader #(
  parameter int NCH        = 3,
  parameter int W          = 8,
  parameter int PRESCALE   = 4,
  parameter int RAMP_DIV   = 16,
  parameter int ACTIVE_LOW = 0,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic           wr_imm,
  input  logic [CHW-1:0] wr_ch,
  input  logic [W-1:0]   wr_duty,
  output logic [NCH-1:0] pwm_out,
  output logic [NCH-1:0] at_target,
  output logic           period_start
);

  localparam int   PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int   RW      = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic ACT_LOW = (ACTIVE_LOW != 0);

  logic [PW-1:0]  presc_q, presc_d;
  logic [W-1:0]   phase_q, phase_d;
  logic [RW-1:0]  ramp_q, ramp_d;
  logic           period_start_q, period_start_d;
  logic [NCH-1:0] pwm_q, pwm_d;
  logic [W-1:0]   cur_q    [NCH];
  logic [W-1:0]   cur_d    [NCH];
  logic [W-1:0]   tgt_q    [NCH];
  logic [W-1:0]   tgt_d    [NCH];
  logic [W-1:0]   shadow_q [NCH];
  logic [W-1:0]   shadow_d [NCH];

  logic tick;
  logic step;
  logic wr_valid;

`ifdef RGB_PWM_FADER_GAMMA_EN
  // Squared duty scaled back to W bits; full scale stays full scale so "always on" survives.
  function automatic logic [W-1:0] duty_map(input logic [W-1:0] x);
    if (x == '1) begin
      return '1;
    end
    return W'(({{W{1'b0}}, x} * {{W{1'b0}}, x}) >> W);
  endfunction
`else
  function automatic logic [W-1:0] duty_map(input logic [W-1:0] x);
    return x;
  endfunction
`endif

  assign tick     = (presc_q == PW'(PRESCALE - 1));
  assign step     = period_start_q && (ramp_q == RW'(RAMP_DIV - 1));
  assign wr_valid = wr_en && (32'(wr_ch) < NCH);

  always_comb begin
    presc_d        = tick ? '0 : presc_q + 1'b1;
    phase_d        = tick ? phase_q + 1'b1 : phase_q;
    period_start_d = tick && (phase_q == '1);
    ramp_d         = ramp_q;
    if (period_start_q) begin
      ramp_d = step ? '0 : ramp_q + 1'b1;
    end
  end

  // A step is judged against the pre-write target; a same-cycle write then overrides what it sets.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cur_d[i] = cur_q[i];
      tgt_d[i] = tgt_q[i];
      if (step) begin
        if (cur_q[i] < tgt_q[i]) begin
          cur_d[i] = cur_q[i] + 1'b1;
        end else if (cur_q[i] > tgt_q[i]) begin
          cur_d[i] = cur_q[i] - 1'b1;
        end
      end
      if (wr_valid && (wr_ch == CHW'(i))) begin
        tgt_d[i] = wr_duty;
        if (wr_imm) begin
          cur_d[i] = wr_duty;
        end
      end
    end
  end

  // Shadow captures the pre-step duty once per period so the comparator never sees a mid-period change.
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < NCH; i++) begin
      shadow_d[i] = period_start_q ? duty_map(cur_q[i]) : shadow_q[i];
      pwm_d[i]    = ((phase_q < shadow_q[i]) || (shadow_q[i] == '1)) ^ ACT_LOW;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q        <= '0;
      phase_q        <= '0;
      ramp_q         <= '0;
      period_start_q <= 1'b0;
      pwm_q          <= {NCH{ACT_LOW}};
      for (int i = 0; i < NCH; i++) begin
        cur_q[i]    <= '0;
        tgt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      presc_q        <= presc_d;
      phase_q        <= phase_d;
      ramp_q         <= ramp_d;
      period_start_q <= period_start_d;
      pwm_q          <= pwm_d;
      for (int i = 0; i < NCH; i++) begin
        cur_q[i]    <= cur_d[i];
        tgt_q[i]    <= tgt_d[i];
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  always_comb begin
    at_target = '0;
    for (int i = 0; i < NCH; i++) begin
      at_target[i] = (cur_q[i] == tgt_q[i]);
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;

endmodule
